// File: rtl/read_data_checker_if.sv
// Read-return bus between the Avalon controller read side and the read-data
// checker.
//   rd_accepted      pulse: a read command was accepted this cycle
//   avl_rdata_valid  a read-return beat is present this cycle
//   avl_rdata        read-return data, qualified by avl_rdata_valid
// Handshake: there is no back-pressure. The checker consumes every beat that is
// presented with avl_rdata_valid=1 in the cycle it appears. rd_accepted marks
// one command accepted by the controller; each such command owes exactly one
// returned beat.
interface read_data_checker_if;
  logic        rd_accepted;
  logic        avl_rdata_valid;
  logic [63:0] avl_rdata;

  modport master (output rd_accepted, output avl_rdata_valid, output avl_rdata);
  modport slave  (input  rd_accepted, input  avl_rdata_valid, input  avl_rdata);
endinterface

// File: rtl/read_data_checker.sv
// read_data_checker: checks DDR3 read-return beats against the word pattern
// written by the command stage (PATTERN ^ beat index, index counting in return
// order). It tracks outstanding reads, runs a watchdog on missing returns,
// records the first mismatch and reports a sticky pass/fail.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   start             level, high once DDR3 calibration succeeded
//   rd                read-return bus (slave side)
//   is_finished       sticky: checking complete
//   pass / fail       sticky verdicts, valid once is_finished=1
//   error_count       mismatching beats, saturating
//   first_err_index   index of the first mismatching beat
//   first_err_data    data of the first mismatching beat
//   timeout           sticky: watchdog expired
//   protocol_err      sticky: beat with nothing outstanding, or counter overflow
//   state_dbg         current FSM state (0 idle, 1 run, 2 done)
module read_data_checker #(
  parameter int          ADDR_W  = 24,
  parameter logic [63:0] PATTERN = 64'hdeadfadebabebeef,
  parameter int          TIMEOUT = 4096,
  parameter int          OUTST_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  read_data_checker_if.slave   rd,
  output logic                 is_finished,
  output logic                 pass,
  output logic                 fail,
  output logic [15:0]          error_count,
  output logic [ADDR_W:0]      first_err_index,
  output logic [63:0]          first_err_data,
  output logic                 timeout,
  output logic                 protocol_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int                WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   LAST_INDEX = {1'b0, {ADDR_W{1'b1}}};

  state_t               state;
  logic [ADDR_W:0]      index;
  logic [OUTST_W-1:0]   outstanding;
  logic [WD_W-1:0]      watchdog;

  logic [63:0] expected;
  logic        mismatch;
  logic        overflow;
  logic        underflow;
  logic        wd_expire;
  logic        clean;

  assign expected  = PATTERN ^ {{(63-ADDR_W){1'b0}}, index};
  assign mismatch  = rd.avl_rdata != expected;
  // An accept paired with a beat is net zero, so neither can trip the counter.
  assign overflow  = rd.rd_accepted && !rd.avl_rdata_valid && (outstanding == '1);
  assign underflow = rd.avl_rdata_valid && !rd.rd_accepted && (outstanding == '0);
  // Expiry fires on the cycle the count would reach TIMEOUT, so the flag is
  // visible exactly TIMEOUT cycles after the last beat.
  assign wd_expire = !rd.avl_rdata_valid && (outstanding != '0) && (watchdog == WD_LIMIT);
  assign clean     = (error_count == 16'd0) && !timeout && !protocol_err;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      index           <= '0;
      outstanding     <= '0;
      watchdog        <= '0;
      is_finished     <= 1'b0;
      pass            <= 1'b0;
      fail            <= 1'b0;
      error_count     <= '0;
      first_err_index <= '0;
      first_err_data  <= '0;
      timeout         <= 1'b0;
      protocol_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_RUN;
        end

        S_RUN: begin
          if (rd.rd_accepted && !rd.avl_rdata_valid) begin
            if (!overflow) outstanding <= outstanding + 1'b1;
          end else if (rd.avl_rdata_valid && !rd.rd_accepted) begin
            if (!underflow) outstanding <= outstanding - 1'b1;
          end

          if (rd.avl_rdata_valid || (outstanding == '0)) watchdog <= '0;
          else                                           watchdog <= watchdog + 1'b1;

          if (rd.avl_rdata_valid) begin
            index <= index + 1'b1;
            if (mismatch) begin
              if (error_count != 16'hffff) error_count <= error_count + 16'd1;
              // error_count saturates, so zero reliably means "no error yet".
              if (error_count == 16'd0) begin
                first_err_index <= index;
                first_err_data  <= rd.avl_rdata;
              end
            end
            if (index == LAST_INDEX) state <= S_DONE;
          end

          // Fatal conditions finish immediately; the verdict is already known.
          if (overflow || underflow) begin
            protocol_err <= 1'b1;
            is_finished  <= 1'b1;
            fail         <= 1'b1;
            state        <= S_DONE;
          end
          if (wd_expire) begin
            timeout     <= 1'b1;
            is_finished <= 1'b1;
            fail        <= 1'b1;
            state       <= S_DONE;
          end
        end

        S_DONE: begin
          is_finished <= 1'b1;
          pass        <= clean;
          fail        <= !clean;
        end

        default: begin
          state        <= S_DONE;
          protocol_err <= 1'b1;
          is_finished  <= 1'b1;
          pass         <= 1'b0;
          fail         <= 1'b1;
        end
      endcase
    end
  end

endmodule
